// File: rtl/axi4lite_pkg.sv
// Shared definitions for the two-requester AXI4-Lite front-end arbiter:
// requester count and controller state encoding.
package axi4lite_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant selection: on contention the requester that was
// not granted last wins; a lone requester always wins.
module rr_arbiter2
    import axi4lite_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               last_grant_i,
    output logic [NUM_REQ-1:0] grant_o
);

    always_comb begin
        // NOTE: default first so every path assigns grant_o and no latch is inferred.
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/axi4lite_arbiter.sv
// Shares one AXI4-Lite master command port between two requesters.
// Define ARB_TIMEOUT_EN to add a WAIT watchdog that errors out after TIMEOUT_CYCLES.
module axi4lite_arbiter
    import axi4lite_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 2,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT_CYCLES     = 64
) (
    input  logic                            m_axi_aclk,
    input  logic                            m_axi_aresetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [2*C_M_AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [2*C_M_AXI_DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                            rsp_err,
    output logic                            start_write,
    output logic                            start_read,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   write_addr,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   write_data,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   read_addr,
    input  logic                            done,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   read_data,
    output logic                            busy
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;

    state_e               state_q;
    logic                 last_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic                 write_q;
    logic [NUM_REQ-1:0]   req_ready_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [DW-1:0]        rsp_rdata_q;
    logic                 start_write_q;
    logic                 start_read_q;
    logic [AW-1:0]        write_addr_q;
    logic [DW-1:0]        write_data_q;
    logic [AW-1:0]        read_addr_q;
    logic                 busy_q;

    logic [NUM_REQ-1:0]   arb_grant;
    logic                 win_idx;
    logic                 win_write;
    logic [AW-1:0]        win_addr;
    logic [DW-1:0]        win_wdata;

    rr_arbiter2 u_rr (
        .req_i        (req_valid),
        .last_grant_i (last_q),
        .grant_o      (arb_grant)
    );

    assign win_idx   = arb_grant[1];
    assign win_write = req_write[win_idx];
    assign win_addr  = win_idx ? req_addr[2*AW-1:AW]   : req_addr[AW-1:0];
    assign win_wdata = win_idx ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             rsp_err_q;
`endif

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            state_q       <= ST_IDLE;
            last_q        <= 1'b1;
            grant_q       <= '0;
            write_q       <= 1'b0;
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            start_write_q <= 1'b0;
            start_read_q  <= 1'b0;
            write_addr_q  <= '0;
            write_data_q  <= '0;
            read_addr_q   <= '0;
            busy_q        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= '0;
            rsp_err_q     <= 1'b0;
`endif
        end else begin
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            start_write_q <= 1'b0;
            start_read_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid) begin
                        grant_q       <= arb_grant;
                        last_q        <= win_idx;
                        write_q       <= win_write;
                        req_ready_q   <= arb_grant;
                        start_write_q <= win_write;
                        start_read_q  <= ~win_write;
                        // Only the address port of the chosen direction moves.
                        if (win_write) begin
                            write_addr_q <= win_addr;
                            write_data_q <= win_wdata;
                        end else begin
                            read_addr_q  <= win_addr;
                        end
                        busy_q  <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
                        rsp_valid_q <= grant_q;
                        rsp_rdata_q <= write_q ? '0 : read_data;
                        state_q     <= ST_RESP;
`ifdef ARB_TIMEOUT_EN
                    end else if (cnt_q == CNT_MAX) begin
                        rsp_valid_q <= grant_q;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                ST_RESP: begin
`ifdef ARB_TIMEOUT_EN
                    rsp_err_q <= 1'b0;
`endif
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign start_write = start_write_q;
    assign start_read  = start_read_q;
    assign write_addr  = write_addr_q;
    assign write_data  = write_data_q;
    assign read_addr   = read_addr_q;
    assign busy        = busy_q;

`ifdef ARB_TIMEOUT_EN
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule
